// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family.
package fifo_pkg;

  // Read-path modes
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Default geometry
  localparam int FIFO_DEF_DW = 16;
  localparam int FIFO_DEF_AW = 4;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port storage: synchronous write, registered or combinational read.
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int DW      = FIFO_DEF_DW,
  parameter int AW      = FIFO_DEF_AW,
  parameter int RD_MODE = FIFO_MODE_STD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write port; contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (RD_MODE == FIFO_MODE_STD) begin : g_reg
      logic [DW-1:0] rdata_q;
      // Registered read: output register loads on re and holds otherwise
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata_q <= '0;
        else if (re) rdata_q <= mem[raddr];
      end
      assign rdata = rdata_q;
    end else begin : g_comb
      logic unused_rd;
      assign unused_rd = rst | re;
      assign rdata     = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with fill level, almost flags, FWFT option, flush and sticky errors.
module sync_fifo_pro
  import fifo_pkg::*;
#(
  parameter int DW       = FIFO_DEF_DW,
  parameter int AW       = FIFO_DEF_AW,
  parameter int FWFT     = FIFO_MODE_STD,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          almost_full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          almost_empty,
  output logic [AW:0]   level,
  input  logic          err_clr,
  output logic          overflow,
  output logic          underflow
);

  localparam int DEPTH = 2**AW;

  // Reject bad configurations at elaboration
  generate
    if (AW < 1) begin : g_bad_aw
      $error("sync_fifo_pro: AW must be >= 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_pro: AF_LEVEL out of range 1..2**AW");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH-1) begin : g_bad_ae
      $error("sync_fifo_pro: AE_LEVEL out of range 0..2**AW-1");
    end
    if (clog2(DEPTH+1) != AW+1) begin : g_bad_lvl
      $error("sync_fifo_pro: level width mismatch");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
      $error("sync_fifo_pro: FWFT must be 0 or 1");
    end
  endgenerate

  localparam logic [AW:0] AF_L = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_L = AE_LEVEL[AW:0];

  logic [AW:0]   wr_ptr, rd_ptr;
  logic          wr_acc, rd_acc;
  logic [DW-1:0] ram_q;

  // Flags straight from registered state, no lag
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  // Flush blocks all traffic; full/empty block their own side
  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  // Pointers and level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky errors; a new error wins over err_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & full  & ~flush) | (overflow  & ~err_clr);
      underflow <= (rd_en & empty & ~flush) | (underflow & ~err_clr);
    end
  end

  fifo_dpram #(
    .DW      (DW),
    .AW      (AW),
    .RD_MODE (FWFT)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_q)
  );

  generate
    if (FWFT == FIFO_MODE_STD) begin : g_std
      logic [1:0] vld_pipe;
      assign vld_pipe[0] = rd_acc;
      // One-cycle valid pulse following each read accept
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        vld_pipe[1] <= 1'b0;
        else if (flush) vld_pipe[1] <= 1'b0;
        else            vld_pipe[1] <= vld_pipe[0];
      end
      assign rd_valid = vld_pipe[1];
      assign rd_data  = ram_q;
    end else begin : g_fwft
      // Head word is presented whenever something is stored
      assign rd_valid = ~empty;
      assign rd_data  = empty ? '0 : ram_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Randomized + directed bench; a standard and an FWFT instance share stimulus
// and are checked against a queue-based model.
module tb_sync_fifo_pro;

  localparam int DW  = 16;
  localparam int AW  = 2;
  localparam int DEP = 4;
  localparam int AFL = 3;
  localparam int AEL = 1;

  logic          clk, rst, flush, wr_en, rd_en, err_clr;
  logic [DW-1:0] wr_data;

  logic          s_full, s_af, s_rv, s_empty, s_ae, s_ovf, s_udf;
  logic [DW-1:0] s_rd;
  logic [AW:0]   s_lvl;
  logic          f_full, f_af, f_rv, f_empty, f_ae, f_ovf, f_udf;
  logic [DW-1:0] f_rd;
  logic [AW:0]   f_lvl;

  sync_fifo_pro #(.DW(DW), .AW(AW), .FWFT(0), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(s_full), .almost_full(s_af), .rd_en(rd_en), .rd_data(s_rd),
    .rd_valid(s_rv), .empty(s_empty), .almost_empty(s_ae), .level(s_lvl),
    .err_clr(err_clr), .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_pro #(.DW(DW), .AW(AW), .FWFT(1), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(f_full), .almost_full(f_af), .rd_en(rd_en), .rd_data(f_rd),
    .rd_valid(f_rv), .empty(f_empty), .almost_empty(f_ae), .level(f_lvl),
    .err_clr(err_clr), .overflow(f_ovf), .underflow(f_udf)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: contents as a queue, plus error bits and std output register
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_sv;
  logic [DW-1:0] m_sd;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    logic [DW-1:0] head;
    sz   = q.size();
    head = (sz > 0) ? q[0] : '0;
    chk("s_level", 32'(s_lvl), 32'(sz));
    chk("f_level", 32'(f_lvl), 32'(sz));
    chk("s_empty", 32'(s_empty), 32'(sz == 0));
    chk("f_empty", 32'(f_empty), 32'(sz == 0));
    chk("s_full",  32'(s_full),  32'(sz == DEP));
    chk("f_full",  32'(f_full),  32'(sz == DEP));
    chk("s_afull", 32'(s_af),    32'(sz >= AFL));
    chk("f_afull", 32'(f_af),    32'(sz >= AFL));
    chk("s_aempty", 32'(s_ae),   32'(sz <= AEL));
    chk("f_aempty", 32'(f_ae),   32'(sz <= AEL));
    chk("s_ovf", 32'(s_ovf), 32'(m_ovf));
    chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
    chk("s_udf", 32'(s_udf), 32'(m_udf));
    chk("f_udf", 32'(f_udf), 32'(m_udf));
    chk("s_rd_valid", 32'(s_rv), 32'(m_sv));
    chk("s_rd_data",  32'(s_rd), 32'(m_sd));
    chk("f_rd_valid", 32'(f_rv), 32'(sz > 0));
    chk("f_rd_data",  32'(f_rd), 32'(head));
  endtask

  // One clock of stimulus: drive on negedge, advance model at posedge, check after
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                      input bit fl = 1'b0, input bit ec = 1'b0);
    int sz;
    bit was_full, was_empty;
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; flush = fl; err_clr = ec;
    @(posedge clk);
    sz        = q.size();
    was_full  = (sz == DEP);
    was_empty = (sz == 0);
    if (fl) begin
      q.delete();
      m_sv = 1'b0;
    end else begin
      m_sv = r && !was_empty;
      if (m_sv) m_sd = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    m_ovf = (w && was_full  && !fl) || (m_ovf && !ec);
    m_udf = (r && was_empty && !fl) || (m_udf && !ec);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_sv = 1'b0; m_sd = '0;
  endtask

  // Async reset pulse strictly between clock edges
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_all();
    #1 rst = 1'b0;

    // Fill, then one overflowing write
    for (int i = 1; i <= 4; i++) step(1, 16'hA000 + 16'(i), 0);
    step(1, 16'hA005, 0);
    // Drain in standard order, then one underflowing read
    for (int i = 0; i < 4; i++) step(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 0, 0, 1);

    // Steady level 2 with concurrent traffic across pointer wrap
    step(1, 16'hC000, 0);
    step(1, 16'hC001, 0);
    for (int i = 2; i < 12; i++) step(1, 16'hC000 + 16'(i), 1);

    // Empty + wr + rd, then full + wr + rd
    step(0, '0, 1);
    step(0, '0, 1);
    step(1, 16'hD000, 1);
    step(0, '0, 0, 0, 1);
    for (int i = 1; i < 4; i++) step(1, 16'hD000 + 16'(i), 0);
    step(1, 16'hDEAD, 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1);

    // FWFT visibility and pop
    step(0, '0, 0, 1, 1);
    step(1, 16'hB0B0, 0);
    step(0, '0, 0);
    step(0, '0, 1);
    step(0, '0, 0);

    // Flush at level 3 with a write pending; errors must survive
    step(0, '0, 1);
    for (int i = 0; i < 3; i++) step(1, 16'hE000 + 16'(i), 0);
    step(1, 16'hEEEE, 0, 1);
    step(0, '0, 0);

    // Overflow coinciding with err_clr keeps overflow set
    for (int i = 0; i < 4; i++) step(1, 16'hF000 + 16'(i), 0);
    step(1, 16'hFFFF, 0, 0, 1);

    // Reset in the middle of a burst
    step(1, 16'h1111, 1);
    step(1, 16'h2222, 0);
    async_reset();
    step(0, '0, 0);

    // Randomized phases biased toward filling or draining
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 40) % 2 == 0) ? 70 : 30;
      step($urandom_range(99) < wp, 16'($urandom), $urandom_range(99) >= wp,
           $urandom_range(29) == 0, $urandom_range(9) == 0);
      if ($urandom_range(149) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
